hamming12_8_decoder: RTL and testbench
======================================

Name: hamming12_8_decoder

Overview:
- Streaming Hamming(12,8) single-error-correcting decoder for the transceiver receive path. It is the receive-side counterpart of the 12/8 coder.
- Accepts 12-bit codewords over a valid/ready handshake and computes the syndrome. It corrects single-bit errors, flags syndromes that cannot be corrected, and delivers 8-bit data through a 2-stage elastic pipeline.

Parameters:
- CNT_W, 16, width of the error statistics counters (used only with HAMMING_ERR_CNT_EN).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  decoder accepts in_code this cycle.
- in_code  in  12  received codeword; bit i = Hamming position i+1.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  8  decoded (corrected) data byte.
- out_corr  out  1  a single-bit error was corrected.
- out_err  out  1  uncorrectable syndrome (13..15).
- out_syndrome  out  4  raw syndrome of the word.
- cnt_clr  in  1  clears the statistics counters.
- corr_cnt  out  CNT_W  saturating count of corrected words.
- err_cnt  out  CNT_W  saturating count of uncorrectable words.

Behaviour:
- Codeword layout:
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Parity is even.
  - Syndrome s = XOR of position indices (1..12) whose bit is 1.
- Stage 1 registers in_code and s.
- Stage 2 applies the correction and extracts the data:
  - s = 0: data as received; corr = 0, err = 0.
  - s = 1..12: bit at position s is inverted before extraction; corr = 1. A flipped parity bit leaves the data unchanged but still sets corr.
  - s = 13..15: no correction; data is extracted raw; err = 1, corr = 0.
- Handshake:
  - A transfer occurs when valid & ready are both high in the same cycle.
  - Each stage loads when its valid is 0 or the next stage consumes that cycle.
  - in_ready = !s1_valid | s1_advance.
  - While out_valid & !out_ready, all out_* fields hold stable.
- Latency and throughput:
  - Latency is 2 cycles from input accept to out_valid when there is no backpressure.
  - Throughput is 1 word per cycle.
  - No bubble is inserted when a stage fills and drains in the same cycle.
- Reset (synchronous):
  - Pipeline valids, out_valid, out_data, out_corr, out_err and out_syndrome go to 0.
  - in_ready is 1 from the first cycle after reset.
  - Words in flight when reset is asserted are dropped.
  - Counters reset to 0.
- Ordering and integrity: words are never reordered, duplicated or lost, whatever the pattern of in_valid and out_ready.

Optional Feature:
- Macro: HAMMING_ERR_CNT_EN.
- Defined:
  - corr_cnt increments by 1 for each output transfer with out_corr = 1.
  - err_cnt increments by 1 for each output transfer with out_err = 1.
  - Both counters saturate at 2^CNT_W - 1.
  - cnt_clr has priority over an increment in the same cycle; the counter becomes 0.
- Undefined: corr_cnt and err_cnt are driven constant 0, cnt_clr is ignored, and no counter flops exist.

Decomposition:
- Package hamming12_8_pkg holds:
  - the data-position constant list;
  - localparams for the code width (12) and data width (8);
  - a syndrome function;
  - a data-extract function.
- Sub-module hamming12_8_syndrome is combinational: in_code in, 4-bit syndrome out. It is shared with future checker blocks.

Test Plan:
- Clean word: in_code=0xA27 (d=0xA5) -> after 2 cycles out_data=0xA5, syndrome=0, corr=0, err=0. Also in_code=0x000 -> out_data=0x00.
- Single data-bit error: in_code=0xA07 (position 6 flipped) -> out_data=0xA5, syndrome=6, corr=1, err=0. Sweep all 12 single flips of 0xA27 -> out_data=0xA5 and syndrome equals the flipped position every time.
- Uncorrectable: in_code=0x226 (positions 1 and 12 flipped) -> syndrome=13, err=1, corr=0, out_data=0x25.
- Backpressure: stream 8 words back to back with out_ready toggled in a random pattern -> output order and values match the inputs; no loss or duplication; outputs stable while stalled; in_ready low only when both stages are full and stalled.
- Reset mid-stream: assert rst with 2 words in flight -> next cycle out_valid=0; in_ready=1; the first word after reset emerges with 2-cycle latency.
- With HAMMING_ERR_CNT_EN: send 3 corrected and 2 uncorrectable words -> corr_cnt=3, err_cnt=2. Then cnt_clr in the same cycle as a corrected transfer -> corr_cnt=0. With CNT_W=2, send 5 corrected words -> corr_cnt saturates at 3.

Source files
------------

// File: rtl/hamming12_8_pkg.sv
// Shared definitions for the Hamming(12,8) receive path: code geometry,
// data bit positions and the syndrome / correction / extraction helpers.
package hamming12_8_pkg;

  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  // Hamming position (1-based) of data bits d0..d7; index 0 is d0.
  localparam logic [DATA_W-1:0][3:0] DATA_POS = {
    4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

  // Highest syndrome that still points at a real bit of the codeword.
  localparam logic [SYN_W-1:0] SYN_LAST_POS = 4'd12;

  // Decoded result carried by the output stage.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              err;
    logic [SYN_W-1:0]  syn;
  } dec_out_t;

  // XOR of the 1-based positions of every set bit (even parity code).
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] s;
    s = 4'd0;
    for (int i = 0; i < CODE_W; i++) begin
      s = s ^ ({SYN_W{code[i]}} & SYN_W'(i + 1));
    end
    return s;
  endfunction

  // Invert the bit the syndrome points at; syndromes 0 and 13..15 leave the word alone.
  function automatic logic [CODE_W-1:0] correct_code(input logic [CODE_W-1:0] code,
                                                     input logic [SYN_W-1:0]  syn);
    logic [CODE_W-1:0] mask;
    if ((syn != 4'd0) && (syn <= SYN_LAST_POS)) begin
      mask = 12'd1 << (syn - 4'd1);
    end else begin
      mask = 12'd0;
    end
    return code ^ mask;
  endfunction

  // Gather d0..d7 from their Hamming positions.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = 8'd0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = code[DATA_POS[i] - 4'd1];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming12_8_syndrome.sv
// Combinational Hamming(12,8) syndrome generator; also reused by checker blocks.
module hamming12_8_syndrome
  import hamming12_8_pkg::*;
(
  input  logic [CODE_W-1:0] in_code,
  output logic [SYN_W-1:0]  syndrome
);

  assign syndrome = calc_syndrome(in_code);

endmodule

// File: rtl/hamming12_8_decoder.sv
// Streaming Hamming(12,8) SEC decoder with a 2-stage elastic pipeline.
// Stage 1 captures the codeword and its syndrome, stage 2 (the output
// register) holds the corrected byte and its status flags.
// Optional macro HAMMING_ERR_CNT_EN adds saturating corrected/uncorrectable
// word counters; without it the counter outputs are tied to zero.
module hamming12_8_decoder
  import hamming12_8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_corr,
  output logic              out_err,
  output logic [3:0]        out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [SYN_W-1:0]  s1_syn_q, s1_syn_d;
  logic              out_valid_q, out_valid_d;
  dec_out_t          out_res_q, out_res_d;

  logic [SYN_W-1:0]  syn_s;
  logic              s2_load_s;
  logic              s1_advance_s;
  logic              in_ready_s;
  dec_out_t          dec_s;

  hamming12_8_syndrome u_syndrome (
    .in_code  (in_code),
    .syndrome (syn_s)
  );

  // A stage may load when it is empty or its content leaves this cycle,
  // so a full pipeline keeps streaming without bubbles.
  assign s2_load_s    = !out_valid_q || out_ready;
  assign s1_advance_s = s1_valid_q && s2_load_s;
  assign in_ready_s   = !s1_valid_q || s1_advance_s;

  // Stage 1 next state: take a new codeword whenever the stage can load.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    if (in_ready_s) begin
      s1_valid_d = in_valid;
      s1_code_d  = in_code;
      s1_syn_d   = syn_s;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Correction and data extraction on the stage 1 contents.
  always_comb begin
    dec_s      = '{data: 8'd0, corr: 1'b0, err: 1'b0, syn: 4'd0};
    dec_s.syn  = s1_syn_q;
    dec_s.data = extract_data(correct_code(s1_code_q, s1_syn_q));
    if (s1_syn_q == 4'd0) begin
      dec_s.corr = 1'b0;
      dec_s.err  = 1'b0;
    end else if (s1_syn_q <= SYN_LAST_POS) begin
      dec_s.corr = 1'b1;
      dec_s.err  = 1'b0;
    end else begin
      dec_s.corr = 1'b0;
      dec_s.err  = 1'b1;
    end
  end

  // Output stage next state: fields only change on a load of a valid word,
  // which keeps them stable while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    if (s2_load_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_res_d = dec_s;
      end else begin
        out_res_d = out_res_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; reset drops every word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= 12'd0;
      s1_syn_q    <= 4'd0;
      out_valid_q <= 1'b0;
      out_res_q   <= '{data: 8'd0, corr: 1'b0, err: 1'b0, syn: 4'd0};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_q;
  assign out_data     = out_res_q.data;
  assign out_corr     = out_res_q.corr;
  assign out_err      = out_res_q.err;
  assign out_syndrome = out_res_q.syn;

`ifdef HAMMING_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             out_xfer_s;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign out_xfer_s = out_valid_q && out_ready;

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d = CNT_ZERO;
      err_cnt_d  = CNT_ZERO;
    end else begin
      if (out_xfer_s && out_res_q.corr && (corr_cnt_q != CNT_MAX)) begin
        corr_cnt_d = corr_cnt_q + CNT_ONE;
      end else begin
        corr_cnt_d = corr_cnt_q;
      end
      if (out_xfer_s && out_res_q.err && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q <= CNT_ZERO;
      err_cnt_q  <= CNT_ZERO;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr;
  assign corr_cnt       = {CNT_W{1'b0}};
  assign err_cnt        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hamming12_8_decoder.sv
// Self-checking bench for hamming12_8_decoder: directed test-plan words,
// randomized streaming with backpressure against a behavioural model,
// mid-stream reset and the statistics counters.
module tb_hamming12_8_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_corr;
  logic        out_err;
  logic [3:0]  out_syndrome;
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  hamming12_8_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corr(out_corr), .out_err(out_err),
    .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .err_cnt(err_cnt)
  );

`ifdef HAMMING_ERR_CNT_EN
  logic        sat_in_ready, sat_out_valid, sat_out_corr, sat_out_err;
  logic [7:0]  sat_out_data;
  logic [3:0]  sat_out_syndrome;
  logic [1:0]  sat_corr_cnt, sat_err_cnt;

  hamming12_8_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_code(in_code), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_data(sat_out_data), .out_corr(sat_out_corr), .out_err(sat_out_err),
    .out_syndrome(sat_out_syndrome), .cnt_clr(cnt_clr),
    .corr_cnt(sat_corr_cnt), .err_cnt(sat_err_cnt)
  );
`endif

  typedef struct {
    logic [7:0] data;
    logic       corr;
    logic       err;
    logic [3:0] syn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   data_pos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  logic       hold_v;
  logic [7:0] h_data;
  logic       h_corr, h_err;
  logic [3:0] h_syn;
  logic       last_acc;

  // Reference decode straight from the code definition.
  function automatic exp_t ref_decode(input logic [11:0] code);
    exp_t        r;
    int          s;
    logic [11:0] fixed;
    s = 0;
    for (int p = 1; p <= 12; p++) if (code[p-1]) s = s ^ p;
    fixed = code;
    if (s >= 1 && s <= 12) fixed[s-1] = ~fixed[s-1];
    for (int k = 0; k < 8; k++) r.data[k] = fixed[data_pos[k]-1];
    r.corr = (s >= 1 && s <= 12);
    r.err  = (s >= 13);
    r.syn  = 4'(s);
    return r;
  endfunction

  // Even-parity encoder: each parity position p covers positions q with (q & p) != 0.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    logic        par;
    c = 12'd0;
    for (int k = 0; k < 8; k++) c[data_pos[k]-1] = d[k];
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q <= 12; q++) if (((q & p) != 0) && (q != p)) par = par ^ c[q-1];
      c[p-1] = par;
    end
    return c;
  endfunction

  // Clean, single-error, double-error or arbitrary word.
  function automatic logic [11:0] rand_word();
    logic [11:0] c;
    int          kind;
    c = encode(8'($urandom));
    kind = $urandom_range(0, 3);
    if (kind == 1) c = c ^ (12'd1 << $urandom_range(0, 11));
    else if (kind == 2) c = c ^ (12'd1 << $urandom_range(0, 11)) ^ (12'd1 << $urandom_range(0, 11));
    else if (kind == 3) c = 12'($urandom);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered at a falling edge: drive, check, book-keep.
  task automatic cycle(input logic iv, input logic [11:0] code, input logic orr, input int exp_ov);
    exp_t e;
    in_valid  = iv;
    in_code   = code;
    out_ready = orr;
    #1;
    if (exp_ov >= 0) chk("latency_out_valid", {31'd0, out_valid}, 32'(exp_ov));
    if (hold_v) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, {24'd0, h_data});
      chk("stall_flags", {26'd0, out_corr, out_err, out_syndrome}, {26'd0, h_corr, h_err, h_syn});
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, !(exp_q.size() == 2 && !orr)});
    if (out_valid && orr) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.data});
        chk("out_corr", {31'd0, out_corr}, {31'd0, e.corr});
        chk("out_err", {31'd0, out_err}, {31'd0, e.err});
        chk("out_syndrome", {28'd0, out_syndrome}, {28'd0, e.syn});
      end
    end
    hold_v = out_valid && !orr;
    h_data = out_data; h_corr = out_corr; h_err = out_err; h_syn = out_syndrome;
    last_acc = iv && in_ready;
    if (last_acc) exp_q.push_back(ref_decode(code));
    @(negedge clk);
  endtask

  // Single word through an empty pipe with fixed expected outputs and latency.
  task automatic directed(input logic [11:0] code, input logic [7:0] ed, input logic [3:0] es,
                          input logic ec, input logic ee);
    cycle(1'b1, code, 1'b1, -1);
    cycle(1'b0, 12'h000, 1'b1, 0);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("dir_valid", {31'd0, out_valid}, 32'd1);
    chk("dir_data", {24'd0, out_data}, {24'd0, ed});
    chk("dir_syndrome", {28'd0, out_syndrome}, {28'd0, es});
    chk("dir_corr", {31'd0, out_corr}, {31'd0, ec});
    chk("dir_err", {31'd0, out_err}, {31'd0, ee});
    cycle(1'b0, 12'h000, 1'b1, -1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) cycle(1'b0, 12'h000, 1'b1, -1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    int          tries;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_code = 12'h000; cnt_clr = 1'b0;
    hold_v = 1'b0; last_acc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_flags", {26'd0, out_corr, out_err, out_syndrome}, 32'd0);
    chk("rst_counters", {corr_cnt, err_cnt}, 32'd0);
    @(negedge clk);

    // Test-plan words.
    directed(12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
    directed(12'h000, 8'h00, 4'd0, 1'b0, 1'b0);
    directed(12'hA07, 8'hA5, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) directed(12'hA27 ^ (12'd1 << i), 8'hA5, 4'(i + 1), 1'b1, 1'b0);
    directed(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);

    // Eight back-to-back words under random backpressure.
    for (int i = 0; i < 8; i++) begin
      w = rand_word();
      tries = 0;
      last_acc = 1'b0;
      while (!last_acc && tries < 50) begin
        cycle(1'b1, w, 1'($urandom_range(0, 1)), -1);
        tries++;
      end
      if (!last_acc) chk("bp_accept_timeout", 32'd1, 32'd0);
    end
    drain();

    // Long randomized stream; an offered word is held until accepted.
    w = rand_word();
    for (int n = 0; n < 400; n++) begin
      cycle(1'(($urandom % 4) != 0), w, 1'(($urandom % 3) != 0), -1);
      if (last_acc) w = rand_word();
    end
    drain();

    // Reset with two words in flight.
    cycle(1'b1, 12'hA27, 1'b0, -1);
    cycle(1'b1, 12'h226, 1'b0, -1);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; exp_q.delete(); hold_v = 1'b0; #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_fields", {18'd0, out_data, out_corr, out_err, out_syndrome}, 32'd0);
    @(negedge clk);
    cycle(1'b1, 12'hA07, 1'b1, -1);
    cycle(1'b0, 12'h000, 1'b1, 0);
    cycle(1'b0, 12'h000, 1'b1, 1);
    drain();

`ifdef HAMMING_ERR_CNT_EN
    cnt_clr = 1'b1; cycle(1'b0, 12'h000, 1'b1, -1); cnt_clr = 1'b0;
    chk("cnt_after_clr", {corr_cnt, err_cnt}, 32'd0);
    directed(12'hA07, 8'hA5, 4'd6, 1'b1, 1'b0);
    directed(12'hA26, 8'hA5, 4'd1, 1'b1, 1'b0);
    directed(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
    directed(12'hA2F, 8'hA5, 4'd4, 1'b1, 1'b0);
    directed(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
    chk("corr_cnt_3", {16'd0, corr_cnt}, 32'd3);
    chk("err_cnt_2", {16'd0, err_cnt}, 32'd2);
    cycle(1'b1, 12'hA07, 1'b1, -1);
    cycle(1'b0, 12'h000, 1'b1, 0);
    cnt_clr = 1'b1; cycle(1'b0, 12'h000, 1'b1, 1); cnt_clr = 1'b0;
    chk("clr_beats_incr", {corr_cnt, err_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) directed(12'hA27 ^ (12'd1 << i), 8'hA5, 4'(i + 1), 1'b1, 1'b0);
    chk("corr_cnt_5", {16'd0, corr_cnt}, 32'd5);
    chk("sat_corr_cnt", {30'd0, sat_corr_cnt}, 32'd3);
    chk("sat_err_cnt", {30'd0, sat_err_cnt}, 32'd0);
`else
    cnt_clr = 1'b1;
    directed(12'h226, 8'h25, 4'd13, 1'b0, 1'b1);
    cnt_clr = 1'b0;
    chk("cnt_tied_zero", {corr_cnt, err_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
